// File: rtl/stack_mem_ctrl_pkg.sv
// Shared definitions for the stack/memory controller: opcode and state encodings
// plus the stack pointer reset value.
package stack_mem_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_LOAD  = 3'b001,
    OP_STORE = 3'b010,
    OP_PUSH  = 3'b011,
    OP_POP   = 3'b100,
    OP_CALL  = 3'b101,
    OP_RET   = 3'b110,
    OP_RSVD  = 3'b111
  } op_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  // Stack starts at the top of memory and grows downward.
  function automatic logic [31:0] sp_reset_value(input int unsigned nbits);
    return (32'd1 << nbits) - 32'd1;
  endfunction

endpackage

// File: rtl/stack_mem_ctrl_stack_pointer.sv
// Stack pointer register with modulo wrap and sticky over/underflow flag.
// One push_word/pop_word strobe moves sp by exactly one word.
module stack_pointer
  import stack_mem_ctrl_pkg::*;
#(
  parameter int num_of_register = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_word,
  input  logic                       pop_word,
  output logic [num_of_register-1:0] sp,
  output logic [num_of_register-1:0] sp_inc,
  output logic                       err
);

  localparam logic [num_of_register-1:0] SP_RST =
    num_of_register'(sp_reset_value(num_of_register));
  localparam logic [num_of_register-1:0] SP_ONE = num_of_register'(1);

  logic [num_of_register-1:0] sp_q, sp_d;
  logic                       err_q, err_d;

  always_comb begin
    sp_d  = sp_q;
    err_d = err_q;
    if (push_word) begin
      sp_d = sp_q - SP_ONE;
      if (sp_q == '0) err_d = 1'b1;
    end else if (pop_word) begin
      sp_d = sp_q + SP_ONE;
      if (sp_q == SP_RST) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q  <= SP_RST;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  assign sp     = sp_q;
  assign sp_inc = sp_q + SP_ONE;
  assign err    = err_q;

endmodule

// File: rtl/stack_mem_ctrl.sv
// Memory-stage controller: LOAD/STORE plus a downward-growing word stack with
// PUSH/POP and two-word CALL/RET that take one extra SECOND cycle.
module stack_mem_ctrl
  import stack_mem_ctrl_pkg::*;
#(
  parameter int data_width      = 16,
  parameter int address_width   = 32,
  parameter int num_of_register = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     op_valid,
  input  logic [2:0]               op_code,
  input  logic [address_width-1:0] ea,
  input  logic [data_width-1:0]    st_data,
  input  logic [31:0]              pc_in,
  output logic                     ready,
  output logic                     mem_we,
  output logic                     mem_re,
  output logic [address_width-1:0] mem_addr,
  output logic [data_width-1:0]    mem_wdata,
  input  logic [data_width-1:0]    mem_rdata,
  output logic                     res_valid,
  output logic [31:0]              res_data,
  output logic [address_width-1:0] sp,
  output logic                     stack_err
);

  // Handshake: an op transfers on a posedge where op_valid && ready; while
  // ready is low the pipeline must hold op_valid/op_code/operands stable.

  state_t                     state_q, state_d;
  logic                       is_call_q, is_call_d;
  logic [15:0]                pc_lo_q, pc_lo_d;
  logic [data_width-1:0]      hold_q, hold_d;
  logic                       res_valid_q, res_valid_d;
  logic [31:0]                res_data_q, res_data_d;

  logic                       push_word, pop_word;
  logic [num_of_register-1:0] sp_w, sp_inc_w;
  logic [address_width-1:0]   sp_addr, pop_addr;

  stack_pointer #(.num_of_register(num_of_register)) u_sp (
    .clk      (clk),
    .rst      (reset),
    .push_word(push_word),
    .pop_word (pop_word),
    .sp       (sp_w),
    .sp_inc   (sp_inc_w),
    .err      (stack_err)
  );

  assign sp_addr  = address_width'(sp_w);
  assign pop_addr = address_width'(sp_inc_w);

  always_comb begin
    state_d     = state_q;
    is_call_d   = is_call_q;
    pc_lo_d     = pc_lo_q;
    hold_d      = hold_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    push_word   = 1'b0;
    pop_word    = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    // Reset gating keeps a held op from reaching memory while reset is high.
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            case (op_t'(op_code))
              OP_LOAD: begin
                mem_re      = 1'b1;
                mem_addr    = ea;
                res_valid_d = 1'b1;
                res_data_d  = 32'(mem_rdata);
              end
              OP_STORE: begin
                mem_we    = 1'b1;
                mem_addr  = ea;
                mem_wdata = st_data;
              end
              OP_PUSH: begin
                mem_we    = 1'b1;
                mem_addr  = sp_addr;
                mem_wdata = st_data;
                push_word = 1'b1;
              end
              OP_POP: begin
                mem_re      = 1'b1;
                mem_addr    = pop_addr;
                pop_word    = 1'b1;
                res_valid_d = 1'b1;
                res_data_d  = 32'(mem_rdata);
              end
              OP_CALL: begin
                mem_we    = 1'b1;
                mem_addr  = sp_addr;
                mem_wdata = data_width'(pc_in[31:16]);
                push_word = 1'b1;
                pc_lo_d   = pc_in[15:0];
                is_call_d = 1'b1;
                state_d   = ST_SECOND;
              end
              OP_RET: begin
                mem_re    = 1'b1;
                mem_addr  = pop_addr;
                pop_word  = 1'b1;
                hold_d    = mem_rdata;
                is_call_d = 1'b0;
                state_d   = ST_SECOND;
              end
              default: ;
            endcase
          end
        end
        ST_SECOND: begin
          state_d = ST_IDLE;
          // sp already moved one word in cycle 1, so both second accesses use it directly.
          if (is_call_q) begin
            mem_we    = 1'b1;
            mem_addr  = sp_addr;
            mem_wdata = data_width'(pc_lo_q);
            push_word = 1'b1;
          end else begin
            mem_re      = 1'b1;
            mem_addr    = pop_addr;
            pop_word    = 1'b1;
            res_valid_d = 1'b1;
            res_data_d  = (32'(mem_rdata) << 16) | 32'(hold_q);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      is_call_q   <= 1'b0;
      pc_lo_q     <= '0;
      hold_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      is_call_q   <= is_call_d;
      pc_lo_q     <= pc_lo_d;
      hold_q      <= hold_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign sp        = sp_addr;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Self-checking bench for stack_mem_ctrl with a behavioural 2048x16 memory
// (combinational read, negedge write) and a result scoreboard.
module tb_stack_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] ea;
  logic [15:0] st_data;
  logic [31:0] pc_in;
  logic        ready;
  logic        mem_we, mem_re;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        res_valid;
  logic [31:0] res_data;
  logic [31:0] sp;
  logic        stack_err;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  logic [15:0] mem [0:2047];
  logic [15:0] model [0:2047];

  localparam logic [2:0] C_NOP = 3'b000, C_LOAD = 3'b001, C_STORE = 3'b010,
                         C_PUSH = 3'b011, C_POP = 3'b100, C_CALL = 3'b101,
                         C_RET = 3'b110;

  stack_mem_ctrl dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .ea(ea), .st_data(st_data), .pc_in(pc_in), .ready(ready),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .res_valid(res_valid),
    .res_data(res_data), .sp(sp), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[10:0]];

  always @(negedge clk) begin
    if (mem_we) mem[mem_addr[10:0]] = mem_wdata;
  end

  // Result monitor: every res_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && res_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_result got=%h expected=none", res_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (res_data !== e) begin
          miscompares++;
          $display("FAIL result got=%h expected=%h", res_data, e);
        end
      end
    end
  end

  task automatic drive(input logic [2:0] c, input logic [31:0] a,
                       input logic [15:0] d, input logic [31:0] p);
    op_valid = 1'b1; op_code = c; ea = a; st_data = d; pc_in = p;
  endtask

  task automatic idle();
    op_valid = 1'b0; op_code = C_NOP; ea = '0; st_data = '0; pc_in = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(C_PUSH, 32'd0, 16'h1111, 32'd0);
    @(negedge clk);
    vectors++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_gate we=%b re=%b expected 0 0", mem_we, mem_re);
    end
    idle();
    repeat (2) step();
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (sp !== 32'd2047) begin miscompares++; $display("FAIL reset_sp got=%0d expected=2047", sp); end
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b expected=1", ready); end
    vectors++;
    if ({mem_we, mem_re, mem_addr, mem_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_mem we=%b re=%b addr=%h wdata=%h expected all 0", mem_we, mem_re, mem_addr, mem_wdata);
    end
    vectors++;
    if (stack_err !== 1'b0 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags err=%b res_valid=%b expected 0 0", stack_err, res_valid);
    end
  endtask

  task automatic test_push_pop();
    step();
    drive(C_PUSH, 32'd0, 16'hAAAA, 32'd0);
    @(negedge clk);
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 32'd2047 || mem_wdata !== 16'hAAAA) begin
      miscompares++;
      $display("FAIL push_access we=%b addr=%0d wdata=%h expected 1 2047 aaaa", mem_we, mem_addr, mem_wdata);
    end
    step();
    vectors++;
    if (sp !== 32'd2046) begin miscompares++; $display("FAIL push_sp got=%0d expected=2046", sp); end
    drive(C_POP, 32'd0, 16'd0, 32'd0);
    exp_q.push_back(32'h0000AAAA);
    @(negedge clk);
    vectors++;
    if (mem_re !== 1'b1 || mem_addr !== 32'd2047) begin
      miscompares++;
      $display("FAIL pop_access re=%b addr=%0d expected 1 2047", mem_re, mem_addr);
    end
    step();
    idle();
    vectors++;
    if (sp !== 32'd2047) begin miscompares++; $display("FAIL pop_sp got=%0d expected=2047", sp); end
    step();
    @(negedge clk);
    vectors++;
    if (res_valid !== 1'b0) begin miscompares++; $display("FAIL pop_pulse res_valid=%b expected=0", res_valid); end
  endtask

  task automatic test_call_ret();
    step();
    drive(C_CALL, 32'd0, 16'd0, 32'h12345678);
    @(negedge clk);
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 32'd2047 || mem_wdata !== 16'h1234) begin
      miscompares++;
      $display("FAIL call1 we=%b addr=%0d wdata=%h expected 1 2047 1234", mem_we, mem_addr, mem_wdata);
    end
    step();
    idle();
    @(negedge clk);
    vectors++;
    if (ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'd2046 || mem_wdata !== 16'h5678) begin
      miscompares++;
      $display("FAIL call2 ready=%b we=%b addr=%0d wdata=%h expected 0 1 2046 5678", ready, mem_we, mem_addr, mem_wdata);
    end
    step();
    vectors++;
    if (sp !== 32'd2045 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL call_end sp=%0d ready=%b expected 2045 1", sp, ready);
    end
    vectors++;
    if (mem[2047] !== 16'h1234 || mem[2046] !== 16'h5678) begin
      miscompares++;
      $display("FAIL call_mem m2047=%h m2046=%h expected 1234 5678", mem[2047], mem[2046]);
    end
    drive(C_RET, 32'd0, 16'd0, 32'd0);
    exp_q.push_back(32'h12345678);
    @(negedge clk);
    vectors++;
    if (mem_re !== 1'b1 || mem_addr !== 32'd2046) begin
      miscompares++;
      $display("FAIL ret1 re=%b addr=%0d expected 1 2046", mem_re, mem_addr);
    end
    step();
    idle();
    @(negedge clk);
    vectors++;
    if (ready !== 1'b0 || mem_re !== 1'b1 || mem_addr !== 32'd2047) begin
      miscompares++;
      $display("FAIL ret2 ready=%b re=%b addr=%0d expected 0 1 2047", ready, mem_re, mem_addr);
    end
    step();
    vectors++;
    if (sp !== 32'd2047) begin miscompares++; $display("FAIL ret_sp got=%0d expected=2047", sp); end
    step();
  endtask

  task automatic test_store_load();
    drive(C_STORE, 32'd5, 16'hBEEF, 32'd0);
    @(negedge clk);
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 32'd5 || mem_wdata !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL store_access we=%b addr=%0d wdata=%h expected 1 5 beef", mem_we, mem_addr, mem_wdata);
    end
    step();
    drive(C_LOAD, 32'd5, 16'd0, 32'd0);
    exp_q.push_back(32'h0000BEEF);
    step();
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a;
      logic [15:0] d;
      a = 32'($urandom_range(16, 200));
      d = 16'($urandom_range(0, 65535));
      model[a[10:0]] = d;
      drive(C_STORE, a, d, 32'd0);
      step();
      a = 32'($urandom_range(16, 200));
      if (model[a[10:0]] !== 16'hxxxx) begin
        drive(C_LOAD, a, 16'd0, 32'd0);
        exp_q.push_back(32'(model[a[10:0]]));
        step();
      end
    end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [4];
    for (int i = 0; i < 4; i++) begin
      vals[i] = 16'($urandom_range(0, 65535));
      drive(C_PUSH, 32'd0, vals[i], 32'd0);
      step();
    end
    vectors++;
    if (sp !== 32'd2043) begin miscompares++; $display("FAIL b2b_sp got=%0d expected=2043", sp); end
    for (int i = 3; i >= 0; i--) begin
      drive(C_POP, 32'd0, 16'd0, 32'd0);
      exp_q.push_back(32'(vals[i]));
      step();
    end
    idle();
    step();
  endtask

  task automatic test_underflow();
    drive(C_STORE, 32'd0, 16'h0C0C, 32'd0);
    step();
    drive(C_POP, 32'd0, 16'd0, 32'd0);
    exp_q.push_back(32'h00000C0C);
    @(negedge clk);
    vectors++;
    if (mem_re !== 1'b1 || mem_addr !== 32'd0) begin
      miscompares++;
      $display("FAIL underflow_addr re=%b addr=%0d expected 1 0", mem_re, mem_addr);
    end
    step();
    vectors++;
    if (sp !== 32'd0 || stack_err !== 1'b1) begin
      miscompares++;
      $display("FAIL underflow_state sp=%0d err=%b expected 0 1", sp, stack_err);
    end
    drive(C_PUSH, 32'd0, 16'h7777, 32'd0);
    @(negedge clk);
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 32'd0) begin
      miscompares++;
      $display("FAIL overflow_addr we=%b addr=%0d expected 1 0", mem_we, mem_addr);
    end
    step();
    idle();
    repeat (3) step();
    vectors++;
    if (sp !== 32'd2047 || stack_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky sp=%0d err=%b expected 2047 1", sp, stack_err);
    end
  endtask

  task automatic test_reset_in_call();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    vectors++;
    if (stack_err !== 1'b0 || sp !== 32'd2047) begin
      miscompares++;
      $display("FAIL rst_clear err=%b sp=%0d expected 0 2047", stack_err, sp);
    end
    mem[2046] = 16'hDEAD;
    drive(C_CALL, 32'd0, 16'd0, 32'hCAFEF00D);
    step();
    idle();
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_second we=%b re=%b ready=%b expected 0 0 1", mem_we, mem_re, ready);
    end
    step();
    reset = 1'b0;
    step();
    vectors++;
    if (sp !== 32'd2047 || ready !== 1'b1 || mem[2046] !== 16'hDEAD) begin
      miscompares++;
      $display("FAIL rst_after sp=%0d ready=%b m2046=%h expected 2047 1 dead", sp, ready, mem[2046]);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 16'h0000;
      model[i] = 16'hxxxx;
    end
    idle();
    test_reset();
    test_push_pop();
    test_call_ret();
    test_store_load();
    test_back_to_back();
    test_underflow();
    test_reset_in_call();
    repeat (3) step();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_results pending=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
